// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-file writer: register map, frame layout and FSM states.
package spi_reg_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 16;
    localparam logic        WRITE_BIT  = 1'b1;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    // Builds the on-wire write frame, MSB transmitted first.
    function automatic spi_frame_t make_frame(input logic [ADDR_W-1:0] addr,
                                              input logic [DATA_W-1:0] data);
        spi_frame_t f;
        f.wr   = WRITE_BIT;
        f.addr = addr;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period generator: counts CLK_DIV cycles per phase, toggles sclk and flags the
// edge about to happen so the controller can act on the same clock.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap      = en && (cnt == CNT_MAX);
    assign rise_tick = wrap && !sclk;
    assign fall_tick = wrap && sclk;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt  <= '0;
                sclk <= !sclk;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_reg_writer.sv
// Mode-0 SPI controller issuing single 16-bit register writes {1, addr[6:0], data[7:0]}.
// Optional SPI_ADDR_FILTER_EN: requests above MAX_ADDR are consumed, flagged on err and not sent.
module spi_reg_writer
    import spi_reg_pkg::*;
#(
    parameter int unsigned       CLK_DIV  = 4,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 7'h04
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sclk,
    output logic              ncs,
    output logic              copi
);

`ifdef SPI_ADDR_FILTER_EN
    localparam logic ADDR_FILTER = 1'b1;
`else
    localparam logic ADDR_FILTER = 1'b0;
`endif

    localparam int unsigned BIT_CNT_W = $clog2(FRAME_BITS);

    state_t                  state;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [FRAME_BITS-2:0]   shreg;
    logic                    rejected;
    logic [FRAME_BITS-1:0]   frame_bits;
    logic                    accept;
    logic                    reject_c;
    logic                    gen_en;
    logic                    gen_clr;
    logic                    rise_tick;
    logic                    fall_tick;

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign frame_bits = make_frame(req_addr, req_data);
    assign reject_c   = ADDR_FILTER && (req_addr > MAX_ADDR);

    // The divider doubles as the HOLD/GAP timer; it is cleared before it can raise sclk there.
    assign gen_en  = (state != IDLE);
    assign gen_clr = (state == IDLE) || (((state == HOLD) || (state == GAP)) && rise_tick);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (gen_en),
        .clr       (gen_clr),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ncs      <= 1'b1;
            copi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rejected <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (reject_c) begin
                            err      <= 1'b1;
                            rejected <= 1'b1;
                            state    <= GAP;
                        end else begin
                            ncs     <= 1'b0;
                            copi    <= frame_bits[FRAME_BITS-1];
                            shreg   <= frame_bits[FRAME_BITS-2:0];
                            bit_cnt <= BIT_CNT_W'(FRAME_BITS - 1);
                            state   <= SHIFT;
                        end
                    end
                end
                // Next bit is presented as sclk falls; the last bit stays on copi into HOLD.
                SHIFT: begin
                    if (fall_tick) begin
                        if (bit_cnt == '0) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                            copi    <= shreg[FRAME_BITS-2];
                            shreg   <= {shreg[FRAME_BITS-3:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (rise_tick) begin
                        ncs   <= 1'b1;
                        copi  <= 1'b0;
                        done  <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (rejected || rise_tick) begin
                        busy     <= 1'b0;
                        rejected <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: CLK_DIV=4 and CLK_DIV=2 instances, frame capture on sclk
// rises and a continuous mode-0 protocol monitor. Follows SPI_ADDR_FILTER_EN like the RTL.
module tb_spi_reg_writer;
    import spi_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid [2];
    logic [6:0] req_addr  [2];
    logic [7:0] req_data  [2];
    logic       req_ready [2];
    logic       busy_w    [2];
    logic       done_w    [2];
    logic       err_w     [2];
    logic       sclk_w    [2];
    logic       ncs_w     [2];
    logic       copi_w    [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, written only by the monitor process.
    logic [15:0] rx      [2] = '{16'h0, 16'h0};
    int rises    [2] = '{0, 0};
    int ncs_low  [2] = '{0, 0};
    int dones    [2] = '{0, 0};
    int errs     [2] = '{0, 0};
    int viol     [2] = '{0, 0};
    int hi_run   [2] = '{0, 0};
    int last_gap [2] = '{0, 0};
    int last_rise[2] = '{0, 0};
    int per_min  [2] = '{1000, 1000};
    int per_max  [2] = '{0, 0};
    bit in_frame [2] = '{1'b0, 1'b0};
    logic p_sclk [2] = '{1'b0, 1'b0};
    logic p_copi [2] = '{1'b0, 1'b0};
    logic p_ncs  [2] = '{1'b1, 1'b1};
    int cyc = 0;

    always #5 clk = ~clk;

    spi_reg_writer #(.CLK_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]), .busy(busy_w[0]), .done(done_w[0]),
        .err(err_w[0]), .sclk(sclk_w[0]), .ncs(ncs_w[0]), .copi(copi_w[0])
    );

    spi_reg_writer #(.CLK_DIV(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]), .busy(busy_w[1]), .done(done_w[1]),
        .err(err_w[1]), .sclk(sclk_w[1]), .ncs(ncs_w[1]), .copi(copi_w[1])
    );

    // Samples every cycle mid-period; copi may only move as sclk falls or as ncs toggles.
    always @(negedge clk) begin
        int per;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (sclk_w[i] && !p_sclk[i]) begin
                rx[i] = {rx[i][14:0], copi_w[i]};
                rises[i]++;
                if (in_frame[i]) begin
                    per = cyc - last_rise[i];
                    if (per < per_min[i]) per_min[i] = per;
                    if (per > per_max[i]) per_max[i] = per;
                end
                in_frame[i]  = 1'b1;
                last_rise[i] = cyc;
                if (ncs_w[i]) viol[i]++;
            end
            if ((copi_w[i] != p_copi[i]) && !(p_sclk[i] && !sclk_w[i]) && (ncs_w[i] == p_ncs[i]))
                viol[i]++;
            if (ncs_w[i]) begin
                hi_run[i]++;
                in_frame[i] = 1'b0;
            end else begin
                if (p_ncs[i]) last_gap[i] = hi_run[i];
                hi_run[i] = 0;
                ncs_low[i]++;
            end
            if (done_w[i]) dones[i]++;
            if (err_w[i]) errs[i]++;
            p_sclk[i] = sclk_w[i];
            p_copi[i] = copi_w[i];
            p_ncs[i]  = ncs_w[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drives a request and returns in the cycle after acceptance (T+1).
    task automatic send(input int i, input logic [6:0] a, input logic [7:0] d, input bit hold);
        int n = 0;
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        req_data[i]  = d;
        while (!req_ready[i] && n < 2000) begin
            step();
            n++;
        end
        check("accept_ready", 32'(req_ready[i]), 32'd1);
        @(posedge clk);
        step();
        if (!hold) req_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done_w[i] && n < 2000);
        check("done_seen", 32'(done_w[i]), 32'd1);
    endtask

    task automatic wait_ready(input int i, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!req_ready[i] && n < 2000);
        check("ready_seen", 32'(req_ready[i]), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, m, r0, nl0, d0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            req_data[i]  = '0;
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            check("rst_ncs",   32'(ncs_w[i]),     32'd1);
            check("rst_sclk",  32'(sclk_w[i]),    32'd0);
            check("rst_copi",  32'(copi_w[i]),    32'd0);
            check("rst_ready", 32'(req_ready[i]), 32'd1);
            check("rst_busy",  32'(busy_w[i]),    32'd0);
        end

        // Single write 0x04/0x80 at CLK_DIV=4: frame 0x8480.
        r0 = rises[0]; nl0 = ncs_low[0]; d0 = dones[0];
        send(0, REG_PWM_DUTY, 8'h80, 1'b0);
        check("t1_ncs",   32'(ncs_w[0]),     32'd0);
        check("t1_copi",  32'(copi_w[0]),    32'd1);
        check("t1_sclk",  32'(sclk_w[0]),    32'd0);
        check("t1_busy",  32'(busy_w[0]),    32'd1);
        check("t1_ready", 32'(req_ready[0]), 32'd0);
        repeat (3) step();
        check("sclk_low_tD", 32'(sclk_w[0]), 32'd0);
        step();
        check("first_rise", 32'(sclk_w[0]), 32'd1);
        wait_done(0, n);
        check("done_latency", 32'(n),              32'd128);
        check("done_ncs_hi",  32'(ncs_w[0]),       32'd1);
        check("frame_8480",   32'(rx[0]),          32'h8480);
        check("rises_16",     32'(rises[0] - r0),  32'd16);
        check("ncs_low_132",  32'(ncs_low[0] - nl0), 32'd132);
        wait_ready(0, n);
        check("done_to_ready", 32'(n),             32'd4);
        check("one_done",     32'(dones[0] - d0),  32'd1);
        check("busy_cleared", 32'(busy_w[0]),      32'd0);

        // Back-to-back with req_valid held: 0x80FF then 0x820F, one frame per 137 cycles.
        send(0, REG_EN_OUT_7_0, 8'hFF, 1'b1);
        req_addr[0] = REG_EN_PWM_7_0;
        req_data[0] = 8'h0F;
        wait_done(0, n);
        check("b2b_frame1", 32'(rx[0]), 32'h80FF);
        wait_ready(0, n);
        check("b2b_ready_gap", 32'(n), 32'd4);
        @(posedge clk);
        step();
        req_valid[0] = 1'b0;
        check("b2b_ncs_gap_ge4", 32'(last_gap[0] >= 4), 32'd1);
        wait_done(0, m);
        check("b2b_period", 32'(n + 1 + m), 32'd137);
        check("b2b_frame2", 32'(rx[0]), 32'h820F);
        wait_ready(0, n);
        check("b2b_no_third", 32'(ncs_w[0]), 32'd1);

        // Reset at the 5th sclk rise aborts the frame without a done pulse.
        r0 = rises[0];
        send(0, REG_EN_PWM_15_8, 8'hA5, 1'b0);
        n = 0;
        while ((rises[0] - r0) < 5 && n < 2000) begin
            step();
            n++;
        end
        check("abort_rise5", 32'(rises[0] - r0), 32'd5);
        rst = 1'b1;
        step();
        check("abort_ncs",  32'(ncs_w[0]),  32'd1);
        check("abort_sclk", 32'(sclk_w[0]), 32'd0);
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        rst = 1'b0;
        d0 = dones[0];
        repeat (200) step();
        check("abort_no_done", 32'(dones[0] - d0), 32'd0);
        send(0, REG_EN_OUT_15_8, 8'h3C, 1'b0);
        wait_done(0, n);
        check("post_abort_frame", 32'(rx[0]), 32'h813C);
        wait_ready(0, n);

        // Out-of-range address 0x10.
        nl0 = ncs_low[0]; d0 = dones[0];
`ifdef SPI_ADDR_FILTER_EN
        send(0, 7'h10, 8'h00, 1'b0);
        check("filt_err",       32'(err_w[0]),     32'd1);
        check("filt_ncs",       32'(ncs_w[0]),     32'd1);
        check("filt_ready_t1",  32'(req_ready[0]), 32'd0);
        step();
        check("filt_ready_t2",  32'(req_ready[0]), 32'd1);
        check("filt_err_pulse", 32'(err_w[0]),     32'd0);
        repeat (20) step();
        check("filt_no_ncs",  32'(ncs_low[0] - nl0), 32'd0);
        check("filt_no_done", 32'(dones[0] - d0),     32'd0);
        check("filt_err_cnt", 32'(errs[0]),           32'd1);
`else
        send(0, 7'h10, 8'h00, 1'b0);
        check("nofilt_err", 32'(err_w[0]), 32'd0);
        wait_done(0, n);
        check("nofilt_frame", 32'(rx[0]),          32'h9000);
        check("nofilt_done",  32'(dones[0] - d0),  32'd1);
        check("nofilt_errs",  32'(errs[0]),        32'd0);
        wait_ready(0, n);
`endif

        // CLK_DIV=2 instance: data 0x55, sclk period 4 cycles, ncs low 66 cycles.
        r0 = rises[1]; nl0 = ncs_low[1];
        send(1, REG_PWM_DUTY, 8'h55, 1'b0);
        wait_done(1, n);
        check("d2_frame",   32'(rx[1]),             32'h8455);
        check("d2_rises",   32'(rises[1] - r0),     32'd16);
        check("d2_ncs_low", 32'(ncs_low[1] - nl0),  32'd66);
        check("d2_per_min", 32'(per_min[1]),        32'd4);
        check("d2_per_max", 32'(per_max[1]),        32'd4);
        wait_ready(1, n);
        check("d2_done_to_ready", 32'(n), 32'd2);

        check("proto_div4", 32'(viol[0]), 32'd0);
        check("proto_div2", 32'(viol[1]), 32'd0);
        check("div4_period_min", 32'(per_min[0]), 32'd8);
        check("div2_err_quiet",  32'(errs[1]),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
